// File: rtl/axi_pkg.sv
// AXI4 write-master shared definitions.
// Provides burst/response encodings, the write FSM state type, a constant
// log2 helper used to derive AWSIZE from the data bus width, and a BRESP
// classifier used for the sticky error flag.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW   = 2'd1,
        WR_W    = 2'd2,
        WR_B    = 2'd3
    } wr_state_e;

    // Ceiling log2 for elaboration-time constants (e.g. AWSIZE).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Anything other than a plain OKAY is treated as an error; EXOKAY is
    // unexpected for non-exclusive writes, so it is flagged too.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY:   err = 1'b0;
            AXI_RESP_EXOKAY: err = 1'b1;
            AXI_RESP_SLVERR: err = 1'b1;
            AXI_RESP_DECERR: err = 1'b1;
            default:         err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_wr_master_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high flush
//   push, din   - write request and data; accepted when not full, or when
//                 full with a pop in the same cycle
//   pop         - consume the head entry
//   dout        - head entry, valid whenever empty is low
//   full, empty - occupancy flags
//   count       - number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        // A pop frees a slot in the same cycle, so a push into a full FIFO
        // alongside a pop is still accepted.
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/axi_wr_master.sv
// axi_wr_master: buffers burst commands and beats from the write-control
// stage and issues them as AXI4 INCR write bursts, one burst in flight.
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   wr_req_en, wr_burst_length,
//   wr_data_addr               - burst command push (len in AWLEN encoding)
//   wr_data_in, wr_data_valid  - beat push into the data FIFO
//   wr_data_last               - informational, unused
//   m_axi_aw*/w*/b*            - AXI4 write address, data and response channels
//   wr_busy                    - FSM active or any FIFO non-empty
//   overflow                   - sticky: a push was refused by a full FIFO
//   bresp_err                  - sticky: a non-OKAY write response was seen
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int DATA_FIFO_DEPTH = 512,
    parameter int CMD_FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_req_en,
    input  logic [7:0]                  wr_burst_length,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_data_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_in,
    input  logic                        wr_data_valid,
    input  logic                        wr_data_last,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic                        wr_busy,
    output logic                        overflow,
    output logic                        bresp_err
);

    localparam int           CMD_W  = AXI_ADDR_WIDTH + 8;
    localparam int           DCNT_W = $clog2(DATA_FIFO_DEPTH) + 1;
    localparam int           CCNT_W = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam logic [2:0]   AWSIZE = 3'(clog2(AXI_DATA_WIDTH / 8));

    wr_state_e state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]                awlen_q, awlen_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic                      overflow_q, overflow_d;
    logic                      bresp_err_q, bresp_err_d;

    logic [CMD_W-1:0]          cmd_dout;
    logic                      cmd_full, cmd_empty, cmd_pop;
    logic [CCNT_W-1:0]         cmd_count;
    logic [AXI_DATA_WIDTH-1:0] data_dout;
    logic                      data_full, data_empty, data_pop;
    logic [DCNT_W-1:0]         data_count;

    logic [7:0]                head_len;
    logic [AXI_ADDR_WIDTH-1:0] head_addr;
    logic                      enough_data;
    logic                      last_beat;

    // Framing comes from the command length, not from the last marker.
    logic unused_inputs;
    assign unused_inputs = ^{wr_data_last, m_axi_bid};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_req_en),
        .din   ({wr_data_addr, wr_burst_length}),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (DATA_FIFO_DEPTH)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data_valid),
        .din   (wr_data_in),
        .pop   (data_pop),
        .dout  (data_dout),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

    assign head_len    = cmd_dout[7:0];
    assign head_addr   = cmd_dout[CMD_W-1:8];
    // Only start a burst once every beat of it is already buffered, so the
    // W phase never starves mid-burst.
    assign enough_data = (data_count >= (DCNT_W'(head_len) + DCNT_W'(1)));
    assign last_beat   = (beat_cnt_q == awlen_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE: if (cmd_pop)                     state_d = WR_AW;
            WR_AW:   if (m_axi_awready)               state_d = WR_W;
            WR_W:    if (data_pop && last_beat)       state_d = WR_B;
            WR_B:    if (m_axi_bvalid)                state_d = WR_IDLE;
            default:                                  state_d = WR_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_pop       = (state_q == WR_IDLE) && !cmd_empty && enough_data;
        m_axi_awvalid = (state_q == WR_AW);
        m_axi_wvalid  = (state_q == WR_W) && !data_empty;
        m_axi_wlast   = m_axi_wvalid && last_beat;
        m_axi_bready  = (state_q == WR_B);
        data_pop      = m_axi_wvalid && m_axi_wready;
    end

    always_comb begin
        awaddr_d    = cmd_pop ? head_addr : awaddr_q;
        awlen_d     = cmd_pop ? head_len  : awlen_q;
        beat_cnt_d  = beat_cnt_q;
        if ((state_q == WR_AW) && m_axi_awready) begin
            beat_cnt_d = '0;
        end else if (data_pop) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
        overflow_d  = overflow_q
                    | (wr_data_valid && data_full && !data_pop)
                    | (wr_req_en && cmd_full && !cmd_pop);
        bresp_err_d = bresp_err_q
                    | ((state_q == WR_B) && m_axi_bvalid && resp_is_error(m_axi_bresp));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            bresp_err_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            bresp_err_q <= bresp_err_d;
        end
    end

    // Address/length are only observed while awvalid is high, so they need
    // no reset.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        awlen_q  <= awlen_d;
    end

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wdata   = data_dout;
    assign m_axi_wstrb   = '1;

    assign wr_busy   = (state_q != WR_IDLE) || !data_empty || (cmd_count != '0);
    assign overflow  = overflow_q;
    assign bresp_err = bresp_err_q;

endmodule

// File: tb/tb_axi_wr_master.sv
module tb_axi_wr_master;

    localparam int DW    = 128;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 512;

    logic            clk;
    logic            reset;
    logic            wr_req_en;
    logic [7:0]      wr_burst_length;
    logic [AW-1:0]   wr_data_addr;
    logic [DW-1:0]   wr_data_in;
    logic            wr_data_valid;
    logic            wr_data_last;
    logic [IW-1:0]   m_axi_awid;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [IW-1:0]   m_axi_bid;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic            wr_busy;
    logic            overflow;
    logic            bresp_err;

    axi_wr_master dut (
        .clk             (clk),
        .reset           (reset),
        .wr_req_en       (wr_req_en),
        .wr_burst_length (wr_burst_length),
        .wr_data_addr    (wr_data_addr),
        .wr_data_in      (wr_data_in),
        .wr_data_valid   (wr_data_valid),
        .wr_data_last    (wr_data_last),
        .m_axi_awid      (m_axi_awid),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awlen     (m_axi_awlen),
        .m_axi_awsize    (m_axi_awsize),
        .m_axi_awburst   (m_axi_awburst),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bid       (m_axi_bid),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .wr_busy         (wr_busy),
        .overflow        (overflow),
        .bresp_err       (bresp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected bursts and beats in issue order.
    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_t;

    aw_t           exp_aw[$];
    logic [DW-1:0] exp_beats[$];
    logic [1:0]    resp_q[$];

    int   checks;
    int   failures;
    int   bursts_done;
    int   beat_idx;
    int   cur_len;
    bit   in_flight;
    int   wready_pct;
    int   aw_delay;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave-side responder: awready after aw_delay cycles, random wready,
    // one B response per burst taken from resp_q (OKAY by default).
    int  aw_wait;
    bit  aw_hs;
    bit  b_hs;
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bid     = '0;
        aw_wait       = 0;
        forever begin
            @(negedge clk);
            aw_hs = m_axi_awvalid && m_axi_awready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            @(posedge clk);
            #1;
            if (reset) begin
                m_axi_awready = 1'b0;
                m_axi_bvalid  = 1'b0;
                aw_wait       = 0;
            end else begin
                if (aw_hs) aw_wait = 0;
                else if (m_axi_awvalid) aw_wait++;
                m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
                if (b_hs) begin
                    m_axi_bvalid = 1'b0;
                end else if (m_axi_bready && !m_axi_bvalid) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                end
            end
            m_axi_wready = ($urandom_range(0, 99) < wready_pct);
        end
    end

    // Protocol monitor compared against the reference model.
    bit            aw_stall;
    bit            w_stall;
    logic [AW-1:0] prev_awaddr;
    logic [7:0]    prev_awlen;
    logic [DW-1:0] prev_wdata;
    logic          prev_wlast;
    aw_t           mon_e;
    logic [DW-1:0] mon_d;
    always @(negedge clk) begin
        if (reset) begin
            aw_stall = 1'b0;
            w_stall  = 1'b0;
        end else begin
            if (aw_stall) begin
                chk("aw_hold_valid", 128'(m_axi_awvalid), 128'(1));
                chk("aw_hold_addr", 128'(m_axi_awaddr), 128'(prev_awaddr));
                chk("aw_hold_len", 128'(m_axi_awlen), 128'(prev_awlen));
            end
            if (m_axi_awvalid && m_axi_awready) begin
                chk("aw_after_prev_b", 128'(in_flight), 128'(0));
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 128'(1), 128'(0));
                end else begin
                    mon_e = exp_aw.pop_front();
                    chk("aw_addr", 128'(m_axi_awaddr), 128'(mon_e.addr));
                    chk("aw_len", 128'(m_axi_awlen), 128'(mon_e.len));
                end
                chk("aw_size", 128'(m_axi_awsize), 128'(4));
                chk("aw_burst", 128'(m_axi_awburst), 128'(1));
                chk("aw_id", 128'(m_axi_awid), 128'(0));
                in_flight = 1'b1;
                beat_idx  = 0;
                cur_len   = int'(m_axi_awlen);
            end
            aw_stall    = m_axi_awvalid && !m_axi_awready;
            prev_awaddr = m_axi_awaddr;
            prev_awlen  = m_axi_awlen;

            if (w_stall) begin
                chk("w_hold_valid", 128'(m_axi_wvalid), 128'(1));
                chk("w_hold_data", 128'(m_axi_wdata), 128'(prev_wdata));
                chk("w_hold_last", 128'(m_axi_wlast), 128'(prev_wlast));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                chk("w_in_burst", 128'(in_flight), 128'(1));
                if (exp_beats.size() == 0) begin
                    chk("w_unexpected", 128'(1), 128'(0));
                end else begin
                    mon_d = exp_beats.pop_front();
                    chk("w_data", 128'(m_axi_wdata), 128'(mon_d));
                end
                chk("w_last", 128'(m_axi_wlast), 128'(beat_idx == cur_len));
                chk("w_strb", 128'(m_axi_wstrb), 128'(16'hFFFF));
                beat_idx++;
            end
            w_stall    = m_axi_wvalid && !m_axi_wready;
            prev_wdata = m_axi_wdata;
            prev_wlast = m_axi_wlast;

            if (m_axi_bvalid && m_axi_bready) begin
                chk("b_after_all_beats", 128'(beat_idx), 128'(cur_len + 1));
                in_flight = 1'b0;
                bursts_done++;
            end
        end
    end

    task automatic push_burst(input logic [AW-1:0] addr, input logic [7:0] len, input bit ramp);
        logic [DW-1:0] d;
        aw_t e;
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clk);
            #1;
            d = ramp ? DW'(i) : {$urandom, $urandom, $urandom, $urandom};
            wr_data_valid = 1'b1;
            wr_data_in    = d;
            wr_data_last  = (i == int'(len));
            wr_req_en     = (i == int'(len));
            if (i == int'(len)) begin
                wr_data_addr    = addr;
                wr_burst_length = len;
            end
            if (exp_beats.size() < DEPTH) exp_beats.push_back(d);
        end
        e.addr = addr;
        e.len  = len;
        exp_aw.push_back(e);
        @(posedge clk);
        #1;
        wr_data_valid = 1'b0;
        wr_data_last  = 1'b0;
        wr_req_en     = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(negedge clk);
            if (!wr_busy && !in_flight && exp_aw.size() == 0 && exp_beats.size() == 0)
                done = 1'b1;
        end
        chk(tag, 128'(done), 128'(1));
    endtask

    // Assert reset for one edge, flush the model, and check the idle state.
    task automatic do_reset(input string pfx);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_aw.delete();
        exp_beats.delete();
        resp_q.delete();
        in_flight = 1'b0;
        beat_idx  = 0;
        @(posedge clk);
        #1;
        chk({pfx, "_awvalid"}, 128'(m_axi_awvalid), 128'(0));
        chk({pfx, "_wvalid"}, 128'(m_axi_wvalid), 128'(0));
        chk({pfx, "_bready"}, 128'(m_axi_bready), 128'(0));
        chk({pfx, "_wr_busy"}, 128'(wr_busy), 128'(0));
        chk({pfx, "_overflow"}, 128'(overflow), 128'(0));
        chk({pfx, "_bresp_err"}, 128'(bresp_err), 128'(0));
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int base;
    logic [DW-1:0] d;
    aw_t e;

    initial begin
        checks          = 0;
        failures        = 0;
        bursts_done     = 0;
        beat_idx        = 0;
        cur_len         = 0;
        in_flight       = 1'b0;
        wready_pct      = 100;
        aw_delay        = 0;
        reset           = 1'b1;
        wr_req_en       = 1'b0;
        wr_burst_length = '0;
        wr_data_addr    = '0;
        wr_data_in      = '0;
        wr_data_valid   = 1'b0;
        wr_data_last    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", 128'(m_axi_awvalid), 128'(0));
        chk("rst_wvalid", 128'(m_axi_wvalid), 128'(0));
        chk("rst_wlast", 128'(m_axi_wlast), 128'(0));
        chk("rst_bready", 128'(m_axi_bready), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_bresp_err", 128'(bresp_err), 128'(0));
        chk("rst_wr_busy", 128'(wr_busy), 128'(0));
        reset = 1'b0;

        // Single 256-beat burst, ramp data, with the 2-cycle start latency.
        push_burst(32'h0000_1000, 8'd255, 1'b1);
        chk("lat_cycle1_awvalid", 128'(m_axi_awvalid), 128'(0));
        @(posedge clk);
        #1;
        chk("lat_cycle2_awvalid", 128'(m_axi_awvalid), 128'(1));
        chk("lat_cycle2_awaddr", 128'(m_axi_awaddr), 128'(32'h0000_1000));
        wait_drain("t1_drain", 3000);
        chk("t1_bursts", 128'(bursts_done), 128'(1));
        chk("t1_bresp_err", 128'(bresp_err), 128'(0));

        // Back-to-back bursts.
        push_burst(32'h0000_0000, 8'd15, 1'b0);
        push_burst(32'h0000_1000, 8'($urandom_range(0, 31)), 1'b0);
        wait_drain("t2_drain", 3000);
        chk("t2_bursts", 128'(bursts_done), 128'(3));

        // Backpressure on AW and W.
        wready_pct = 50;
        aw_delay   = 10;
        push_burst(32'h0000_2000, 8'($urandom_range(0, 63)), 1'b0);
        push_burst(32'h0000_3000, 8'($urandom_range(0, 63)), 1'b0);
        wait_drain("t3_drain", 3000);
        chk("t3_bursts", 128'(bursts_done), 128'(5));
        wready_pct = 100;
        aw_delay   = 0;

        // Error response followed by a good one.
        resp_q.push_back(2'b10);
        push_burst(32'h0000_4000, 8'($urandom_range(0, 31)), 1'b0);
        wait_drain("t4a_drain", 3000);
        chk("t4_err_after_b1", 128'(bresp_err), 128'(1));
        resp_q.push_back(2'b00);
        push_burst(32'h0000_5000, 8'($urandom_range(0, 31)), 1'b0);
        wait_drain("t4b_drain", 3000);
        chk("t4_err_sticky", 128'(bresp_err), 128'(1));
        chk("t4_bursts", 128'(bursts_done), 128'(7));
        chk("t4_no_overflow", 128'(overflow), 128'(0));

        // Overflow: 513 beats into a 512-deep FIFO with nothing draining.
        do_reset("t5_rst");
        base       = bursts_done;
        wready_pct = 0;
        for (int i = 0; i < 513; i++) begin
            @(posedge clk);
            #1;
            if (i == 512) chk("t5_ovf_before_513", 128'(overflow), 128'(0));
            d = {$urandom, $urandom, $urandom, $urandom};
            wr_data_valid = 1'b1;
            wr_data_in    = d;
            if (exp_beats.size() < DEPTH) exp_beats.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_data_valid = 1'b0;
        chk("t5_ovf_on_513", 128'(overflow), 128'(1));
        for (int k = 0; k < 2; k++) begin
            e.addr = (k == 0) ? 32'h0000_6000 : 32'h0000_7000;
            e.len  = 8'd255;
            wr_req_en       = 1'b1;
            wr_data_addr    = e.addr;
            wr_burst_length = e.len;
            exp_aw.push_back(e);
            @(posedge clk);
            #1;
        end
        wr_req_en  = 1'b0;
        wready_pct = 100;
        wait_drain("t5_drain", 3000);
        chk("t5_bursts", 128'(bursts_done - base), 128'(2));
        chk("t5_ovf_sticky", 128'(overflow), 128'(1));

        // Reset in the middle of a burst, then a fresh burst.
        do_reset("t6_rst_pre");
        push_burst(32'h0000_8000, 8'd255, 1'b0);
        for (int c = 0; c < 2000 && beat_idx < 100; c++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_reached_beat100", 128'(beat_idx >= 100), 128'(1));
        do_reset("t6_rst_mid");
        base = bursts_done;
        push_burst(32'h0000_9000, 8'd63, 1'b0);
        wait_drain("t6_drain", 3000);
        chk("t6_bursts", 128'(bursts_done - base), 128'(1));
        chk("t6_bresp_err", 128'(bresp_err), 128'(0));
        chk("t6_overflow", 128'(overflow), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
